// File: rtl/genius_pkg.sv
// Shared types and constants for the Genius round controller.
// Colour encoding and the index/round widths match the external sequence memory.
package genius_pkg;

   localparam int COLOR_W = 2;
   localparam int IDX_W   = 4;
   localparam int ROUND_W = 5;

   localparam logic [COLOR_W-1:0] ZERO = 2'd0;
   localparam logic [COLOR_W-1:0] ONE  = 2'd1;
   localparam logic [COLOR_W-1:0] TWO  = 2'd2;
   localparam logic [COLOR_W-1:0] NO_COLOR = 2'd3;

   localparam int unsigned MAX_ROUND_DEF = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_SHOW,
      ST_GAP,
      ST_WAIT_IN,
      ST_WIN,
      ST_LOSE
   } state_e;

endpackage

// File: rtl/genius_round_ctrl_if.sv
// Game-facing bundle: start, sequence memory link, player buttons, LEDs and status.
// The controller takes the master side; the game board / memory take the slave side.
interface genius_round_ctrl_if;
   import genius_pkg::*;

   logic                 start;
   logic [IDX_W-1:0]     sequence_count;
   logic [COLOR_W-1:0]   current_number;
   logic                 btn_valid;
   logic [COLOR_W-1:0]   btn_color;
   logic                 led_en;
   logic [COLOR_W-1:0]   led_color;
   logic [ROUND_W-1:0]   round;
   logic                 win;
   logic                 lose;

   modport master (
      input  start, current_number, btn_valid, btn_color,
      output sequence_count, led_en, led_color, round, win, lose
   );

   modport slave (
      output start, current_number, btn_valid, btn_color,
      input  sequence_count, led_en, led_color, round, win, lose
   );

endinterface

// File: rtl/genius_round_ctrl_phase_timer.sv
// Loadable down-counter shared by the lit and dark playback phases.
// done_o pulses for one cycle once the loaded count has run out.
module phase_timer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] value_i,
   output logic             done_o
);

   logic [WIDTH-1:0] count_q;
   logic             running_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q   <= '0;
         running_q <= 1'b0;
      end else if (clear_i) begin
         count_q   <= '0;
         running_q <= 1'b0;
      end else if (load_i) begin
         count_q   <= value_i;
         running_q <= 1'b1;
      end else if (running_q) begin
         if (count_q == '0) begin
            running_q <= 1'b0;
         end else begin
            count_q <= count_q - 1'b1;
         end
      end
   end

   assign done_o = running_q && (count_q == '0);

endmodule

// File: rtl/genius_round_ctrl.sv
// Round controller for the Genius (Simon) game: plays back the first N colours
// from the external sequence memory, then checks the player's presses against them.
module genius_round_ctrl
   import genius_pkg::*;
#(
   parameter int unsigned SHOW_ON   = 25_000_000,
   parameter int unsigned SHOW_OFF  = 12_500_000,
   parameter int unsigned MAX_ROUND = MAX_ROUND_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   genius_round_ctrl_if.master bus
);

   localparam int unsigned T_MAX   = (SHOW_ON > SHOW_OFF) ? SHOW_ON : SHOW_OFF;
   localparam int          TIMER_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;
   localparam logic [TIMER_W-1:0] ON_LOAD  = TIMER_W'(SHOW_ON - 1);
   localparam logic [TIMER_W-1:0] OFF_LOAD = TIMER_W'(SHOW_OFF - 1);
   localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(MAX_ROUND);

   state_e               state_q;
   logic [IDX_W-1:0]     idx_q;
   logic [ROUND_W-1:0]   round_q;
   logic                 phaseShow_q;
   logic                 fetchCnt_q;
   logic [COLOR_W-1:0]   expected_q;
   logic                 ledEn_q;
   logic [COLOR_W-1:0]   ledColor_q;
   logic                 win_q;
   logic                 lose_q;

   logic                 timerLoad;
   logic [TIMER_W-1:0]   timerValue;
   logic                 timerDone;
   logic [IDX_W-1:0]     lastIdx;
   logic                 isLast;
   logic                 isMatch;

   assign lastIdx = IDX_W'(round_q - ROUND_W'(1));
   assign isLast  = (idx_q == lastIdx);
   assign isMatch = (bus.btn_color != NO_COLOR) && (bus.btn_color == expected_q);

   // The timer is armed on the edge that enters SHOW and again on the edge that enters GAP.
   always_comb begin
      timerLoad  = 1'b0;
      timerValue = '0;
      if (!bus.start) begin
         if (state_q == ST_FETCH && fetchCnt_q && phaseShow_q) begin
            timerLoad  = 1'b1;
            timerValue = ON_LOAD;
         end else if (state_q == ST_SHOW && timerDone) begin
            timerLoad  = 1'b1;
            timerValue = OFF_LOAD;
         end
      end
   end

   phase_timer #(
      .WIDTH (TIMER_W)
   ) u_phase_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear_i (bus.start),
      .load_i  (timerLoad),
      .value_i (timerValue),
      .done_o  (timerDone)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         round_q     <= '0;
         phaseShow_q <= 1'b1;
         fetchCnt_q  <= 1'b0;
         expected_q  <= ZERO;
         ledEn_q     <= 1'b0;
         ledColor_q  <= ZERO;
         win_q       <= 1'b0;
         lose_q      <= 1'b0;
      end else if (bus.start) begin
         state_q     <= ST_FETCH;
         idx_q       <= '0;
         round_q     <= ROUND_W'(1);
         phaseShow_q <= 1'b1;
         fetchCnt_q  <= 1'b0;
         ledEn_q     <= 1'b0;
         ledColor_q  <= ZERO;
         win_q       <= 1'b0;
         lose_q      <= 1'b0;
      end else begin
         case (state_q)
            // Memory answers two edges after the index moves, so FETCH spans two cycles.
            ST_FETCH: begin
               if (!fetchCnt_q) begin
                  fetchCnt_q <= 1'b1;
               end else begin
                  fetchCnt_q <= 1'b0;
                  expected_q <= bus.current_number;
                  if (phaseShow_q) begin
                     state_q    <= ST_SHOW;
                     ledEn_q    <= 1'b1;
                     ledColor_q <= bus.current_number;
                  end else begin
                     state_q <= ST_WAIT_IN;
                  end
               end
            end
            ST_SHOW: begin
               if (timerDone) begin
                  state_q    <= ST_GAP;
                  ledEn_q    <= 1'b0;
                  ledColor_q <= ZERO;
               end
            end
            ST_GAP: begin
               if (timerDone) begin
                  state_q <= ST_FETCH;
                  if (isLast) begin
                     idx_q       <= '0;
                     phaseShow_q <= 1'b0;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
            end
            ST_WAIT_IN: begin
               if (bus.btn_valid) begin
                  if (!isMatch) begin
                     state_q <= ST_LOSE;
                     lose_q  <= 1'b1;
                  end else if (!isLast) begin
                     state_q <= ST_FETCH;
                     idx_q   <= idx_q + 1'b1;
                  end else if (round_q == LAST_ROUND) begin
                     state_q <= ST_WIN;
                     win_q   <= 1'b1;
                  end else begin
                     state_q     <= ST_FETCH;
                     round_q     <= round_q + 1'b1;
                     idx_q       <= '0;
                     phaseShow_q <= 1'b1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.sequence_count = idx_q;
   assign bus.led_en         = ledEn_q;
   assign bus.led_color      = ledColor_q;
   assign bus.round          = round_q;
   assign bus.win            = win_q;
   assign bus.lose           = lose_q;

endmodule

// File: tb/tb_genius_round_ctrl.sv
// Self-checking bench for genius_round_ctrl: a timeline model of each game round
// (playback windows, fetch gaps, presses) checked against the DUT cycle by cycle.
module tb_genius_round_ctrl;
   import genius_pkg::*;

   localparam int SHOW_ON   = 4;
   localparam int SHOW_OFF  = 2;
   localparam int MAX_ROUND = 16;
   localparam int PER_COLOR = 2 + SHOW_ON + SHOW_OFF;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   assertCount = 0;
   int   failCount = 0;
   logic [1:0] seqMem [16];

   always #5 clk = ~clk;

   genius_round_ctrl_if ifc ();

   genius_round_ctrl #(
      .SHOW_ON   (SHOW_ON),
      .SHOW_OFF  (SHOW_OFF),
      .MAX_ROUND (MAX_ROUND)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   // Sequence memory: one register stage, so a new index is answered two edges later.
   always @(posedge clk) ifc.current_number <= seqMem[ifc.sequence_count];

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      assertCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic checkStatus(input string tag, input int expLed, input int expColor,
                              input int expRound, input int expWin, input int expLose);
      checkOutput({tag, ".led_en"}, 32'(ifc.led_en), expLed);
      checkOutput({tag, ".led_color"}, 32'(ifc.led_color), expColor);
      checkOutput({tag, ".round"}, 32'(ifc.round), expRound);
      checkOutput({tag, ".win"}, 32'(ifc.win), expWin);
      checkOutput({tag, ".lose"}, 32'(ifc.lose), expLose);
   endtask

   task automatic applyStimulus(input logic startIn, input logic btnValid, input logic [1:0] btnColor);
      ifc.start     = startIn;
      ifc.btn_valid = btnValid;
      ifc.btn_color = btnColor;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic noisePress(input bit noise);
      applyStimulus(1'b0, noise && ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)));
   endtask

   task automatic startGame();
      applyStimulus(1'b1, 1'b0, 2'd0);
      step();
      applyStimulus(1'b0, 1'b0, 2'd0);
   endtask

   // Called just after the edge that begins round r; returns just after WAIT_IN is entered.
   task automatic playRound(input int r, input bit noise);
      logic lit;
      for (int k = 0; k < r; k++) begin
         for (int c = 0; c < PER_COLOR; c++) begin
            lit = (c >= 2) && (c < 2 + SHOW_ON);
            checkStatus("play", int'(lit), lit ? int'(seqMem[k]) : 0, r, 0, 0);
            checkOutput("play.seq_count", 32'(ifc.sequence_count), k);
            noisePress(noise);
            step();
         end
      end
      for (int c = 0; c < 2; c++) begin
         checkStatus("fetchIn", 0, 0, r, 0, 0);
         checkOutput("fetchIn.seq_count", 32'(ifc.sequence_count), 0);
         noisePress(noise);
         step();
      end
      applyStimulus(1'b0, 1'b0, 2'd0);
   endtask

   // Presses for round r; wrongAt < 0 means every press is correct.
   task automatic inputRound(input int r, input int wrongAt, input int wrongVal);
      int waitCycles;
      logic [1:0] colour;
      for (int k = 0; k < r; k++) begin
         waitCycles = $urandom_range(0, 3);
         for (int w = 0; w < waitCycles; w++) begin
            checkStatus("waitIn", 0, 0, r, 0, 0);
            checkOutput("waitIn.seq_count", 32'(ifc.sequence_count), k);
            step();
         end
         if (k == wrongAt) begin
            colour = (wrongVal >= 0) ? 2'(wrongVal) : seqMem[k] + 2'($urandom_range(1, 3));
         end else begin
            colour = seqMem[k];
         end
         applyStimulus(1'b0, 1'b1, colour);
         step();
         applyStimulus(1'b0, 1'b0, 2'd0);
         if (k == wrongAt) begin
            checkStatus("lose", 0, 0, r, 0, 1);
            return;
         end
         if (k < r - 1) begin
            for (int c = 0; c < 2; c++) begin
               checkStatus("pressFetch", 0, 0, r, 0, 0);
               checkOutput("pressFetch.seq_count", 32'(ifc.sequence_count), k + 1);
               applyStimulus(1'b0, 1'b1, 2'd3);
               step();
            end
            applyStimulus(1'b0, 1'b0, 2'd0);
         end else if (r == MAX_ROUND) begin
            checkStatus("win", 0, 0, r, 1, 0);
            return;
         end
      end
   endtask

   task automatic holdCheck(input string tag, input int cycles, input int expRound,
                            input int expWin, input int expLose);
      for (int c = 0; c < cycles; c++) begin
         checkStatus(tag, 0, 0, expRound, expWin, expLose);
         noisePress(1'b1);
         step();
      end
      applyStimulus(1'b0, 1'b0, 2'd0);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int wrongRound;
      seqMem = '{2'd2, 2'd1, 2'd0, 2'd1, 2'd0, 2'd2, 2'd1, 2'd2,
                 2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd1, 2'd0, 2'd1};
      applyStimulus(1'b0, 1'b0, 2'd0);
      rst_n = 1'b0;
      step();
      step();
      checkStatus("reset", 0, 0, 0, 0, 0);
      checkOutput("reset.seq_count", 32'(ifc.sequence_count), 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      holdCheck("idle", 4, 0, 0, 0);
      checkOutput("idle.seq_count", 32'(ifc.sequence_count), 0);

      $display("[TB] round 1 and 2 playback, then wrong second press");
      startGame();
      playRound(1, 1'b0);
      inputRound(1, -1, -1);
      playRound(2, 1'b0);
      inputRound(2, 1, 0);
      holdCheck("loseHold", 6, 2, 0, 1);

      $display("[TB] full game with ignored presses during playback");
      startGame();
      for (int r = 1; r <= MAX_ROUND; r++) begin
         playRound(r, 1'b1);
         inputRound(r, -1, -1);
      end
      holdCheck("winHold", 20, MAX_ROUND, 1, 0);

      $display("[TB] start clears win, then restart in round 3 wait");
      startGame();
      playRound(1, 1'b0);
      inputRound(1, -1, -1);
      playRound(2, 1'b0);
      inputRound(2, -1, -1);
      playRound(3, 1'b0);
      applyStimulus(1'b1, 1'b1, seqMem[0] + 2'd1);
      step();
      applyStimulus(1'b0, 1'b0, 2'd0);
      playRound(1, 1'b0);
      inputRound(1, -1, -1);

      $display("[TB] asynchronous reset during SHOW");
      startGame();
      step();
      step();
      step();
      checkStatus("preReset", 1, int'(seqMem[0]), 1, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      checkStatus("asyncReset", 0, 0, 0, 0, 0);
      checkOutput("asyncReset.seq_count", 32'(ifc.sequence_count), 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      holdCheck("postReset", 6, 0, 0, 0);
      startGame();
      playRound(1, 1'b0);

      $display("[TB] randomized games");
      for (int g = 0; g < 4; g++) begin
         for (int i = 6; i < 16; i++) seqMem[i] = 2'($urandom_range(0, 2));
         wrongRound = $urandom_range(1, 5);
         startGame();
         for (int r = 1; r <= wrongRound; r++) begin
            playRound(r, 1'b1);
            inputRound(r, (r == wrongRound) ? int'($urandom_range(0, r - 1)) : -1, -1);
         end
         holdCheck("randLose", 3, wrongRound, 0, 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
